// File: rtl/attention_softmax_if.sv
// Handshake and payload bundle between the score stage and the softmax block.
interface attention_softmax_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned L          = 8,
  parameter int unsigned N          = 1
);
  localparam int unsigned VEC_W = DATA_WIDTH * L * N * L;

  logic             start;
  logic [VEC_W-1:0] A_in;
  logic             done;
  logic             out_valid;
  logic [VEC_W-1:0] P_out;

  modport master (output start, A_in, input done, out_valid, P_out);
  modport slave  (input start, A_in, output done, out_valid, P_out);
endinterface

// File: rtl/attention_softmax.sv
// Row-wise base-2 softmax over the L x N x L score cube, one row at a time,
// with a shared multi-cycle restoring divider for normalisation.
module attention_softmax #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned L          = 8,
  parameter int unsigned N          = 1,
  parameter int unsigned OUT_FRAC   = 15
) (
  input logic               clk,
  input logic               rst,
  attention_softmax_if.slave bus
);
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned TOTAL = L * N * L;
  localparam int unsigned ROWS  = L * N;
  localparam int unsigned IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned CNT_W = $clog2(DW + 1);
  localparam int unsigned D_W   = DW + 1;
  localparam int unsigned W_W   = OUT_FRAC + 1;
  localparam int unsigned SUM_W = OUT_FRAC + 1 + $clog2(L);
  localparam int unsigned NUM_W = DW + SUM_W;
  localparam int unsigned VEC_W = DW * TOTAL;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MAX  = 3'd2,
    S_SUM  = 3'd3,
    S_DIV  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t state, state_next;

  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    mx;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] rem;
  logic [DW-1:0]    quo;

  logic [DW-1:0]  a_mem    [TOTAL];
  logic [DW-1:0]  a_in_arr [TOTAL];
  logic [W_W-1:0] w_mem    [L];
  logic [DW-1:0]  res_mem  [TOTAL];
  logic [VEC_W-1:0] res_flat;

  logic [IDX_W-1:0] idx;
  logic             col_last;
  logic             row_last;
  logic             cnt_last;
  logic [DW-1:0]    a_cur;
  logic [D_W-1:0]   d;
  logic [W_W-1:0]   w_cur;
  logic [W_W-1:0]   w_div;
  logic [NUM_W-1:0] num;
  logic [SUM_W:0]   trial;
  logic [SUM_W:0]   diff;
  logic             q_bit;
  logic [SUM_W-1:0] rem_next;
  logic [DW-1:0]    quo_next;

  // Unpack the score bus and pack the result buffer, element by element.
  for (genvar g = 0; g < int'(TOTAL); g++) begin : g_pack
    assign a_in_arr[g]              = bus.A_in[g*DW +: DW];
    assign res_flat[g*DW +: DW]     = res_mem[g];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic: load, then per row max / sum / divide, then publish.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (bus.start) state_next = S_LOAD;
      S_LOAD: state_next = S_MAX;
      S_MAX:  if (col_last) state_next = S_SUM;
      S_SUM:  if (col_last) state_next = S_DIV;
      S_DIV:  if (cnt_last && col_last) state_next = row_last ? S_DONE : S_MAX;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath helpers: element address, exponent weight and one divider step.
  always_comb begin
    idx      = IDX_W'(row) * IDX_W'(L) + IDX_W'(col);
    col_last = (col == COL_W'(L - 1));
    row_last = (row == ROW_W'(ROWS - 1));
    cnt_last = (cnt == CNT_W'(DW));
    a_cur    = a_mem[idx];
    // Sign-extended difference; one extra bit keeps max - min from wrapping.
    d        = {mx[DW-1], mx} - {a_cur[DW-1], a_cur};
    w_cur    = '0;
    if (d <= D_W'(OUT_FRAC)) w_cur = (W_W'(1) << OUT_FRAC) >> d;
    w_div    = w_mem[col];
    num      = NUM_W'(w_div) << OUT_FRAC;
    // Remainder stays below the sum, so the borrow bit alone decides the quotient bit.
    trial    = {rem, quo[DW-1]};
    diff     = trial - {1'b0, sum};
    q_bit    = ~diff[SUM_W];
    rem_next = q_bit ? diff[SUM_W-1:0] : trial[SUM_W-1:0];
    quo_next = {quo[DW-2:0], q_bit};
  end

  // Counters, accumulators, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      row           <= '0;
      col           <= '0;
      cnt           <= '0;
      mx            <= '0;
      sum           <= '0;
      rem           <= '0;
      quo           <= '0;
      a_mem         <= '{default: '0};
      w_mem         <= '{default: '0};
      res_mem       <= '{default: '0};
      bus.done      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.P_out     <= '0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            row           <= '0;
            col           <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          a_mem <= a_in_arr;
        end
        S_MAX: begin
          if (col == '0 || $signed(a_cur) > $signed(mx)) mx <= a_cur;
          col <= col_last ? '0 : col + COL_W'(1);
          sum <= '0;
        end
        S_SUM: begin
          w_mem[col] <= w_cur;
          sum        <= sum + SUM_W'(w_cur);
          col        <= col_last ? '0 : col + COL_W'(1);
        end
        S_DIV: begin
          if (cnt == '0) begin
            // The high part of the numerator is already below the sum,
            // so DW iterations produce the whole quotient.
            rem <= num[NUM_W-1:DW];
            quo <= num[DW-1:0];
            cnt <= cnt + CNT_W'(1);
          end else begin
            rem <= rem_next;
            quo <= quo_next;
            if (cnt_last) begin
              res_mem[idx] <= quo_next;
              cnt          <= '0;
              col          <= col_last ? '0 : col + COL_W'(1);
              if (col_last) row <= row + ROW_W'(1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_DONE: begin
          bus.P_out     <= res_flat;
          bus.done      <= 1'b1;
          bus.out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_attention_softmax.sv
// Bench for attention_softmax: directed and random scenarios on an L=8,N=1
// instance and random scenarios on an L=4,N=2 instance.
module tb_attention_softmax;
  localparam int unsigned VEC0 = 16 * 64;
  localparam int unsigned VEC1 = 16 * 32;
  localparam int T0 = 1218;
  localparam int T1 = 2 + 8 * (8 + 4 * 17);
  localparam int BUDGET = 3000;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   last_exp0[];

  attention_softmax_if #(.DATA_WIDTH(16), .L(8), .N(1)) bus0 ();
  attention_softmax_if #(.DATA_WIDTH(16), .L(4), .N(2)) bus1 ();

  attention_softmax #(.DATA_WIDTH(16), .L(8), .N(1), .OUT_FRAC(15)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  attention_softmax #(.DATA_WIDTH(16), .L(4), .N(2), .OUT_FRAC(15)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Reference: base-2 softmax per row (l outer, n inner) with truncating division.
  task automatic model(input int sc[], input int ll, input int nn, output int p[]);
    p = new[sc.size()];
    for (int l = 0; l < ll; l++) begin
      for (int n = 0; n < nn; n++) begin
        int base;
        int m;
        longint s;
        longint w[];
        base = (l * nn + n) * ll;
        m = sc[base];
        for (int j = 1; j < ll; j++) if (sc[base+j] > m) m = sc[base+j];
        w = new[ll];
        s = 0;
        for (int j = 0; j < ll; j++) begin
          longint dd;
          dd = longint'(m) - longint'(sc[base+j]);
          w[j] = (dd <= 15) ? (longint'(32768) >> dd) : 0;
          s += w[j];
        end
        for (int j = 0; j < ll; j++) p[base+j] = int'((w[j] * 32768) / s);
      end
    end
  endtask

  function automatic logic [VEC0-1:0] pack0(input int sc[]);
    logic [VEC0-1:0] v;
    v = '0;
    for (int k = 0; k < 64; k++) v[k*16 +: 16] = 16'(sc[k]);
    return v;
  endfunction

  function automatic logic [VEC1-1:0] pack1(input int sc[]);
    logic [VEC1-1:0] v;
    v = '0;
    for (int k = 0; k < 32; k++) v[k*16 +: 16] = 16'(sc[k]);
    return v;
  endfunction

  // Caller is at a negedge; pulse start for one edge and count edges until done.
  task automatic start_wait0(output int lat, output logic ov_after_accept);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    ov_after_accept = bus0.out_valid;
    lat = 0;
    while (bus0.done !== 1'b1 && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start_wait1(output int lat);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 0;
    while (bus1.done !== 1'b1 && lat < BUDGET) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus0.done); end
    checks++;
    if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", bus0.out_valid); end
    checks++;
    if (bus0.P_out !== '0) begin errors++; $display("FAIL reset_p_out got nonzero expected 0"); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_uniform();
    int sc[];
    int exp[];
    int lat;
    int got;
    logic ov;
    sc = new[64];
    foreach (sc[k]) sc[k] = 5;
    model(sc, 8, 1, exp);
    bus0.A_in = pack0(sc);
    start_wait0(lat, ov);
    bus0.A_in = '1;
    checks++;
    if (lat != T0) begin errors++; $display("FAIL uniform_latency got %0d expected %0d", lat, T0); end
    for (int k = 0; k < 64; k++) begin
      got = int'(bus0.P_out[k*16 +: 16]);
      checks++;
      if (got !== exp[k] || got !== 4096) begin
        errors++; $display("FAIL uniform_p[%0d] got %0d expected %0d", k, got, exp[k]);
      end
    end
    @(negedge clk);
    checks++;
    if (bus0.done !== 1'b0) begin errors++; $display("FAIL uniform_done_pulse got %b expected 0", bus0.done); end
    checks++;
    if (bus0.out_valid !== 1'b1) begin errors++; $display("FAIL uniform_out_valid got %b expected 1", bus0.out_valid); end
    last_exp0 = exp;
  endtask

  task automatic test_dominant();
    int sc[];
    int exp[];
    int lat;
    int got;
    logic ov;
    sc = new[64];
    foreach (sc[k]) sc[k] = 5;
    sc[0] = 10;
    for (int j = 1; j < 8; j++) sc[j] = 9;
    model(sc, 8, 1, exp);
    bus0.A_in = pack0(sc);
    start_wait0(lat, ov);
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL dominant_valid_clear got %b expected 0", ov); end
    checks++;
    if (lat != T0) begin errors++; $display("FAIL dominant_latency got %0d expected %0d", lat, T0); end
    got = int'(bus0.P_out[15:0]);
    checks++;
    if (got !== 7281) begin errors++; $display("FAIL dominant_p0 got %0d expected 7281", got); end
    got = int'(bus0.P_out[31:16]);
    checks++;
    if (got !== 3640) begin errors++; $display("FAIL dominant_p1 got %0d expected 3640", got); end
    for (int k = 0; k < 64; k++) begin
      got = int'(bus0.P_out[k*16 +: 16]);
      checks++;
      if (got !== exp[k]) begin errors++; $display("FAIL dominant_p[%0d] got %0d expected %0d", k, got, exp[k]); end
    end
    last_exp0 = exp;
  endtask

  // Start issued in the same cycle done is visible: the FSM is already idle.
  task automatic test_back_to_back();
    int sc[];
    int exp[];
    int lat;
    int got;
    logic ov;
    sc = new[64];
    foreach (sc[k]) sc[k] = 0;
    sc[0]  = 0;
    sc[1]  = -32768;
    for (int j = 2; j < 8; j++) sc[j] = -32768;
    sc[8]  = 32767;
    for (int j = 9; j < 16; j++) sc[j] = 0;
    for (int k = 16; k < 64; k++) sc[k] = int'($urandom_range(0, 40)) - 20;
    model(sc, 8, 1, exp);
    bus0.A_in = pack0(sc);
    start_wait0(lat, ov);
    checks++;
    if (lat != T0) begin errors++; $display("FAIL b2b_latency got %0d expected %0d", lat, T0); end
    got = int'(bus0.P_out[15:0]);
    checks++;
    if (got !== 32768) begin errors++; $display("FAIL extreme_row0_p0 got %0d expected 32768", got); end
    got = int'(bus0.P_out[8*16 +: 16]);
    checks++;
    if (got !== 32768) begin errors++; $display("FAIL extreme_row1_p0 got %0d expected 32768", got); end
    for (int k = 0; k < 64; k++) begin
      got = int'(bus0.P_out[k*16 +: 16]);
      checks++;
      if (got !== exp[k]) begin errors++; $display("FAIL extreme_p[%0d] got %0d expected %0d", k, got, exp[k]); end
    end
    last_exp0 = exp;
  endtask

  // Starts during the run (including the publish cycle) must be ignored.
  task automatic test_ignored_start();
    int sc[];
    int exp[];
    int lat;
    int got;
    sc = new[64];
    foreach (sc[k]) sc[k] = int'($urandom_range(0, 30)) - 15;
    model(sc, 8, 1, exp);
    bus0.A_in = pack0(sc);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    lat = 0;
    while (lat < BUDGET) begin
      @(negedge clk);
      lat++;
      bus0.start = (lat == 5 || lat == 500 || lat == T0 - 1);
      if (lat == 500) begin
        checks++;
        if (bus0.P_out !== pack0(last_exp0)) begin
          errors++; $display("FAIL ignored_p_hold got changed P_out expected previous result");
        end
      end
      if (bus0.done === 1'b1) break;
    end
    bus0.start = 1'b0;
    checks++;
    if (lat != T0) begin errors++; $display("FAIL ignored_latency got %0d expected %0d", lat, T0); end
    for (int k = 0; k < 64; k++) begin
      got = int'(bus0.P_out[k*16 +: 16]);
      checks++;
      if (got !== exp[k]) begin errors++; $display("FAIL ignored_p[%0d] got %0d expected %0d", k, got, exp[k]); end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.out_valid !== 1'b1 || bus0.done !== 1'b0) begin
      errors++; $display("FAIL ignored_done_cycle_start got valid=%b done=%b expected valid=1 done=0", bus0.out_valid, bus0.done);
    end
    last_exp0 = exp;
  endtask

  task automatic test_reset_mid();
    int sc[];
    int exp[];
    int lat;
    int got;
    int seen;
    logic ov;
    sc = new[64];
    foreach (sc[k]) sc[k] = int'($urandom_range(0, 65535)) - 32768;
    bus0.A_in = pack0(sc);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus0.done !== 1'b0 || bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got done=%b valid=%b expected 0 0", bus0.done, bus0.out_valid);
    end
    checks++;
    if (bus0.P_out !== '0) begin errors++; $display("FAIL midreset_p_out got nonzero expected 0"); end
    seen = 0;
    repeat (1300) begin
      @(negedge clk);
      if (bus0.done === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_no_done got %0d pulses expected 0", seen); end
    foreach (sc[k]) sc[k] = int'($urandom_range(0, 24)) - 12;
    model(sc, 8, 1, exp);
    bus0.A_in = pack0(sc);
    start_wait0(lat, ov);
    checks++;
    if (lat != T0) begin errors++; $display("FAIL midreset_latency got %0d expected %0d", lat, T0); end
    for (int k = 0; k < 64; k++) begin
      got = int'(bus0.P_out[k*16 +: 16]);
      checks++;
      if (got !== exp[k]) begin errors++; $display("FAIL midreset_p[%0d] got %0d expected %0d", k, got, exp[k]); end
    end
  endtask

  task automatic test_multihead();
    int sc[];
    int exp[];
    int lat;
    int got;
    sc = new[32];
    for (int t = 0; t < 5; t++) begin
      foreach (sc[k]) begin
        if (t == 0) sc[k] = int'($urandom_range(0, 65535)) - 32768;
        else        sc[k] = int'($urandom_range(0, 8 * t)) - 4 * t + 1000 * (k % 4 == 0 ? 0 : 0);
      end
      if (t == 2) sc[5] = sc[4];
      model(sc, 4, 2, exp);
      bus1.A_in = pack1(sc);
      start_wait1(lat);
      checks++;
      if (lat != T1) begin errors++; $display("FAIL multihead_latency[%0d] got %0d expected %0d", t, lat, T1); end
      for (int k = 0; k < 32; k++) begin
        got = int'(bus1.P_out[k*16 +: 16]);
        checks++;
        if (got !== exp[k]) begin
          errors++; $display("FAIL multihead[%0d]_p[%0d] got %0d expected %0d", t, k, got, exp[k]);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus0.start = 1'b0;
    bus0.A_in  = '0;
    bus1.start = 1'b0;
    bus1.A_in  = '0;
    test_reset();
    test_uniform();
    test_dominant();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid();
    test_multihead();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
